// File: rtl/l2_arbiter.sv
// Two-requester round-robin arbiter in front of a single-outstanding L2 port; min latency request->ready is 3 cycles.
// Requests are level-held until ready; the non-owner simply waits, and an L2 access that never answers times out with err.
module l2_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        rd_req,
    input  logic [1:0]        wr_req,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        ready,
    output logic              err,
    output logic [1:0]        grant,
    output logic              l2_read_req,
    output logic              l2_write_req,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [DATA_W-1:0] l2_write_data,
    input  logic [DATA_W-1:0] l2_read_data,
    input  logic              l2_ready
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic              owner;
    logic              last_grant;
    logic              is_wr;
    logic              err_q;
    logic [7:0]        cnt;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        req_any;
    logic              sel;
    logic              timeout_hit;
    logic [1:0]        owner_oh;

    assign req_any     = rd_req | wr_req;
    assign timeout_hit = (cnt == CNT_LAST);
    assign owner_oh    = owner ? 2'b10 : 2'b01;

    // Lone requester wins outright; on contention the one not served last wins.
    always_comb begin
        sel = ~last_grant;
        if (req_any == 2'b01) begin
            sel = 1'b0;
        end else if (req_any == 2'b10) begin
            sel = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (|req_any) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (l2_ready || timeout_hit) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner         <= 1'b0;
            last_grant    <= 1'b1;
            is_wr         <= 1'b0;
            err_q         <= 1'b0;
            cnt           <= 8'd0;
            rdata_q       <= '0;
            l2_addr       <= '0;
            l2_write_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req_any) begin
                        owner         <= sel;
                        is_wr         <= wr_req[sel];
                        l2_addr       <= sel ? req_addr1 : req_addr0;
                        l2_write_data <= sel ? req_wdata1 : req_wdata0;
                    end
                end
                S_ISSUE: begin
                    cnt     <= 8'd0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
                S_WAIT: begin
                    if (l2_ready) begin
                        if (!is_wr) begin
                            rdata_q <= l2_read_data;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (timeout_hit) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    last_grant <= owner;
                end
                default: ;
            endcase
        end
    end

    // rdata_q is cleared at issue, so writes and timeouts return zero.
    always_comb begin
        grant        = 2'b00;
        ready        = 2'b00;
        err          = 1'b0;
        rdata        = '0;
        l2_read_req  = 1'b0;
        l2_write_req = 1'b0;
        case (state)
            S_ISSUE: begin
                grant        = owner_oh;
                l2_read_req  = ~is_wr;
                l2_write_req = is_wr;
            end
            S_WAIT: begin
                grant = owner_oh;
            end
            S_RESP: begin
                grant = owner_oh;
                ready = owner_oh;
                err   = err_q;
                rdata = rdata_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter: stimulus pushes expected L2 issues and ready responses, monitors pop and compare.
module tb_l2_arbiter;

    logic         clk;
    logic         rst;
    logic [1:0]   rd_req;
    logic [1:0]   wr_req;
    logic [31:0]  req_addr0;
    logic [31:0]  req_addr1;
    logic [127:0] req_wdata0;
    logic [127:0] req_wdata1;
    logic [127:0] rdata;
    logic [1:0]   ready;
    logic         err;
    logic [1:0]   grant;
    logic         l2_read_req;
    logic         l2_write_req;
    logic [31:0]  l2_addr;
    logic [127:0] l2_write_data;
    logic [127:0] resp_data;
    logic         resp_rdy;
    logic         stray_rdy;
    logic         l2_ready;
    logic         mute;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [1:0]   rdy;
        logic         err;
        logic [127:0] rdata;
        int           cyc;
    } rsp_t;

    typedef struct {
        logic [1:0]   gnt;
        logic         wr;
        logic [31:0]  addr;
        logic [127:0] wd;
    } l2x_t;

    rsp_t rsp_q[$];
    l2x_t l2_q[$];

    assign l2_ready = resp_rdy | stray_rdy;

    l2_arbiter #(.ADDR_W(32), .DATA_W(128), .TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_req        (rd_req),
        .wr_req        (wr_req),
        .req_addr0     (req_addr0),
        .req_addr1     (req_addr1),
        .req_wdata0    (req_wdata0),
        .req_wdata1    (req_wdata1),
        .rdata         (rdata),
        .ready         (ready),
        .err           (err),
        .grant         (grant),
        .l2_read_req   (l2_read_req),
        .l2_write_req  (l2_write_req),
        .l2_addr       (l2_addr),
        .l2_write_data (l2_write_data),
        .l2_read_data  (resp_data),
        .l2_ready      (l2_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic exp_rsp(input logic [1:0] r, input logic e, input logic [127:0] d, input int c);
        rsp_t x;
        x.rdy = r; x.err = e; x.rdata = d; x.cyc = c;
        rsp_q.push_back(x);
    endtask

    task automatic exp_l2(input logic [1:0] g, input logic w, input logic [31:0] a, input logic [127:0] d);
        l2x_t x;
        x.gnt = g; x.wr = w; x.addr = a; x.wd = d;
        l2_q.push_back(x);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant"}, 128'(grant), 128'(2'b00));
        chk({tag, "_ready"}, 128'(ready), 128'(2'b00));
        chk({tag, "_err"}, 128'(err), 128'(1'b0));
        chk({tag, "_rdata"}, rdata, 128'h0);
        chk({tag, "_l2_rd"}, 128'(l2_read_req), 128'(1'b0));
        chk({tag, "_l2_wr"}, 128'(l2_write_req), 128'(1'b0));
        chk({tag, "_l2_addr"}, 128'(l2_addr), 128'h0);
        chk({tag, "_l2_wdata"}, l2_write_data, 128'h0);
    endtask

    // Holds its request until n ready pulses have been seen, then drops it.
    task automatic requester(input logic idx, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [127:0] d, input int n);
        if (idx == 1'b0) begin
            req_addr0 = a; req_wdata0 = d;
        end else begin
            req_addr1 = a; req_wdata1 = d;
        end
        rd_req[idx] = rd;
        wr_req[idx] = wr;
        for (int k = 0; k < n; k++) begin
            int t;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!ready[idx] && t < 80);
            checks++;
            if (!ready[idx]) begin
                errors++;
                $display("FAIL wait_ready%0d: no ready pulse within %0d cycles, required one", idx, t);
                break;
            end
        end
        @(posedge clk);
        #1;
        rd_req[idx] = 1'b0;
        wr_req[idx] = 1'b0;
    endtask

    // Ready-side monitor.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (ready != 2'b00) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got ready=%b, required no pulse (t=%0t)", ready, $time);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_ready", 128'(ready), 128'(e.rdy));
                    chk("rsp_err", 128'(err), 128'(e.err));
                    chk("rsp_rdata", rdata, e.rdata);
                    if (e.cyc >= 0) chk("rsp_cycle", 128'(cyc), 128'(e.cyc));
                end
            end
        end
    end

    // L2-side monitor and one-cycle-latency responder.
    initial begin
        l2x_t x;
        resp_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && (l2_read_req || l2_write_req)) begin
                if (l2_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_l2_req: got rd=%b wr=%b, required none", l2_read_req, l2_write_req);
                end else begin
                    x = l2_q.pop_front();
                    chk("l2_op", 128'({l2_write_req, l2_read_req}), 128'(x.wr ? 2'b10 : 2'b01));
                    chk("l2_grant", 128'(grant), 128'(x.gnt));
                    chk("l2_addr", 128'(l2_addr), 128'(x.addr));
                    if (x.wr) chk("l2_wdata", l2_write_data, x.wd);
                end
                if (!mute) begin
                    @(posedge clk);
                    #1 resp_rdy = 1'b1;
                    @(posedge clk);
                    #1 resp_rdy = 1'b0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        rst        = 1'b0;
        rd_req     = 2'b00;
        wr_req     = 2'b00;
        req_addr0  = '0;
        req_addr1  = '0;
        req_wdata0 = '0;
        req_wdata1 = '0;
        resp_data  = '0;
        stray_rdy  = 1'b0;
        mute       = 1'b0;

        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Contention straight after reset: requester 0 first, then the write of requester 1.
        @(posedge clk); #1;
        resp_data = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        exp_l2(2'b01, 1'b0, 32'h0000_1100, 128'h0);
        exp_l2(2'b10, 1'b1, 32'h0000_2200, 128'hFEED_0000_0000_0000_0000_0000_0000_BEEF);
        exp_rsp(2'b01, 1'b0, resp_data, cyc + 3);
        exp_rsp(2'b10, 1'b0, 128'h0, cyc + 7);
        fork
            requester(1'b0, 1'b1, 1'b0, 32'h0000_1100, 128'h0, 1);
            requester(1'b1, 1'b0, 1'b1, 32'h0000_2200, 128'hFEED_0000_0000_0000_0000_0000_0000_BEEF, 1);
        join

        // Fairness: both held for three accesses each, grants alternate starting with 01.
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            exp_l2(2'b01, 1'b0, 32'h0000_2000, 128'h0);
            exp_l2(2'b10, 1'b1, 32'h0000_3000, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
            exp_rsp(2'b01, 1'b0, resp_data, cyc + 3 + 8 * k);
            exp_rsp(2'b10, 1'b0, 128'h0, cyc + 7 + 8 * k);
        end
        fork
            requester(1'b0, 1'b1, 1'b0, 32'h0000_2000, 128'h0, 3);
            requester(1'b1, 1'b0, 1'b1, 32'h0000_3000, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 3);
        join

        // Single read at minimum latency.
        @(posedge clk); #1;
        resp_data = {16{8'hA5}};
        exp_l2(2'b01, 1'b0, 32'h0000_1000, 128'h0);
        exp_rsp(2'b01, 1'b0, {16{8'hA5}}, cyc + 3);
        requester(1'b0, 1'b1, 1'b0, 32'h0000_1000, 128'h0, 1);

        // Timeout: L2 never answers, four WAIT cycles then err.
        @(posedge clk); #1;
        mute = 1'b1;
        exp_l2(2'b10, 1'b1, 32'h0000_4000, 128'hDEAD_BEEF);
        exp_rsp(2'b10, 1'b1, 128'h0, cyc + 6);
        requester(1'b1, 1'b0, 1'b1, 32'h0000_4000, 128'hDEAD_BEEF, 1);
        mute = 1'b0;

        @(posedge clk); #1;
        resp_data = 128'hCAFE_F00D_0000_0000_0000_0000_1234_5678;
        exp_l2(2'b01, 1'b0, 32'h0000_5000, 128'h0);
        exp_rsp(2'b01, 1'b0, 128'hCAFE_F00D_0000_0000_0000_0000_1234_5678, cyc + 3);
        requester(1'b0, 1'b1, 1'b0, 32'h0000_5000, 128'h0, 1);

        // Stray l2_ready while idle is ignored.
        @(posedge clk); #1;
        stray_rdy = 1'b1;
        resp_data = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
        @(negedge clk);
        chk("stray_grant", 128'(grant), 128'(2'b00));
        chk("stray_l2_req", 128'({l2_write_req, l2_read_req}), 128'(2'b00));
        @(posedge clk); #1;
        stray_rdy = 1'b0;
        @(negedge clk);
        chk("stray_after_grant", 128'(grant), 128'(2'b00));

        // rd_req and wr_req together on one requester: issued as a write.
        @(posedge clk); #1;
        exp_l2(2'b01, 1'b1, 32'h0000_6000, 128'hABCD_0000_0000_0000_0000_0000_0000_0042);
        exp_rsp(2'b01, 1'b0, 128'h0, cyc + 3);
        requester(1'b0, 1'b1, 1'b1, 32'h0000_6000, 128'hABCD_0000_0000_0000_0000_0000_0000_0042, 1);

        // Reset in the middle of WAIT: outputs clear at once, no ready pulse.
        @(posedge clk); #1;
        mute = 1'b1;
        exp_l2(2'b10, 1'b0, 32'h0000_7000, 128'h0);
        req_addr1 = 32'h0000_7000;
        rd_req[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rd_req[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("midwait_rst");
        repeat (3) @(negedge clk);
        rst  = 1'b1;
        mute = 1'b0;

        @(posedge clk); #1;
        resp_data = 128'h7777_0000_0000_0000_0000_0000_0000_0001;
        exp_l2(2'b10, 1'b0, 32'h0000_8000, 128'h0);
        exp_rsp(2'b10, 1'b0, 128'h7777_0000_0000_0000_0000_0000_0000_0001, cyc + 3);
        requester(1'b1, 1'b1, 1'b0, 32'h0000_8000, 128'h0, 1);

        repeat (5) @(negedge clk);
        chk("rsp_queue_drained", 128'(rsp_q.size()), 128'h0);
        chk("l2_queue_drained", 128'(l2_q.size()), 128'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
